// File: rtl/tsmac_rx_frame_parser.sv
// GMII receive parser: strips preamble/SFD from FIFO words and emits a framed byte stream
// with length limits and saturating frame statistics.
module tsmac_rx_frame_parser #(
  parameter int unsigned MAX_LEN = 1522,
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             rd_clk,
  input  logic             rd_rst_n,
  input  logic             fifo_rd_vld,
  input  logic [9:0]       fifo_rd_data,
  output logic             fifo_rd_en,
  output logic [7:0]       out_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             out_sof,
  output logic             out_eof,
  output logic             out_err,
  output logic [CNT_W-1:0] frm_len,
  output logic [CNT_W-1:0] frm_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {StIdle, StPre, StData, StDrop} state_e;

  localparam logic [7:0]       Preamble = 8'h55;
  localparam logic [7:0]       Sfd      = 8'hD5;
  localparam logic [CNT_W-1:0] MaxLenC  = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] MinLenC  = CNT_W'(MIN_LEN);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e           state_q, state_d;
  logic             run_q;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             sof_pend_q, sof_pend_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] len_q, len_d;

  logic [7:0]       out_data_q, out_data_d;
  logic             out_vld_q, out_vld_d;
  logic             out_sof_q, out_sof_d;
  logic             out_eof_q, out_eof_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] out_len_q, out_len_d;

  logic [CNT_W-1:0] frm_len_q, frm_len_d;
  logic [CNT_W-1:0] frm_cnt_q, frm_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             consumed;
  logic             rx_er, rx_dv;
  logic [7:0]       rxd;
  logic             emit, emit_eof, emit_err, drop_inc;
  logic [CNT_W-1:0] emit_len;

  assign rx_er = fifo_rd_data[9];
  assign rx_dv = fifo_rd_data[8];
  assign rxd   = fifo_rd_data[7:0];

  // In DATA a consumed word may emit, so only pop when the output register can take it.
  assign fifo_rd_en = run_q & ((state_q != StData) | ~out_vld_q | out_rdy);
  assign consumed   = fifo_rd_en & fifo_rd_vld;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sof_pend_d  = sof_pend_q;
    err_d       = err_q;
    len_d       = len_q;
    emit        = 1'b0;
    emit_eof    = 1'b0;
    emit_err    = 1'b0;
    emit_len    = len_q;
    drop_inc    = 1'b0;

    if (consumed) begin
      case (state_q)
        StIdle: begin
          if (rx_dv) begin
            if (rxd == Preamble) begin
              state_d = StPre;
            end else if (rxd == Sfd) begin
              state_d     = StData;
              len_d       = '0;
              err_d       = 1'b0;
              sof_pend_d  = 1'b1;
              hold_full_d = 1'b0;
            end else begin
              state_d  = StDrop;
              drop_inc = 1'b1;
            end
          end
        end
        StPre: begin
          if (!rx_dv) begin
            state_d  = StIdle;
            drop_inc = 1'b1;
          end else if (rxd == Sfd) begin
            state_d     = StData;
            len_d       = '0;
            err_d       = 1'b0;
            sof_pend_d  = 1'b1;
            hold_full_d = 1'b0;
          end else if (rxd != Preamble) begin
            state_d  = StDrop;
            drop_inc = 1'b1;
          end
        end
        StData: begin
          if (rx_dv) begin
            if (len_q == MaxLenC) begin
              // Byte MAX_LEN+1: close the frame on the held byte and discard the rest.
              emit        = hold_full_q;
              emit_eof    = 1'b1;
              emit_err    = 1'b1;
              emit_len    = MaxLenC;
              hold_full_d = 1'b0;
              state_d     = StDrop;
            end else begin
              emit        = hold_full_q;
              hold_d      = rxd;
              hold_full_d = 1'b1;
              len_d       = len_q + CNT_W'(1);
              err_d       = err_q | rx_er;
            end
          end else begin
            state_d = StIdle;
            if (hold_full_q) begin
              emit        = 1'b1;
              emit_eof    = 1'b1;
              emit_err    = err_q | (len_q < MinLenC);
              hold_full_d = 1'b0;
            end else begin
              drop_inc = 1'b1;
            end
          end
        end
        StDrop: begin
          if (!rx_dv) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    if (emit) sof_pend_d = 1'b0;
  end

  always_comb begin
    out_data_d = out_data_q;
    out_vld_d  = out_vld_q & ~out_rdy;
    out_sof_d  = out_sof_q;
    out_eof_d  = out_eof_q;
    out_err_d  = out_err_q;
    out_len_d  = out_len_q;
    frm_len_d  = frm_len_q;
    frm_cnt_d  = frm_cnt_q;
    err_cnt_d  = err_cnt_q;
    drop_cnt_d = drop_cnt_q;

    if (emit) begin
      out_data_d = hold_q;
      out_vld_d  = 1'b1;
      out_sof_d  = sof_pend_q;
      out_eof_d  = emit_eof;
      out_err_d  = emit_err;
      out_len_d  = emit_len;
    end

    if (out_vld_q && out_rdy && out_eof_q) begin
      frm_len_d = out_len_q;
      if (out_err_q) err_cnt_d = sat_inc(err_cnt_q);
      else           frm_cnt_d = sat_inc(frm_cnt_q);
    end

    if (drop_inc) drop_cnt_d = sat_inc(drop_cnt_q);
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q     <= StIdle;
      run_q       <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sof_pend_q  <= 1'b0;
      err_q       <= 1'b0;
      len_q       <= '0;
      out_data_q  <= '0;
      out_vld_q   <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_len_q   <= '0;
      frm_len_q   <= '0;
      frm_cnt_q   <= '0;
      err_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sof_pend_q  <= sof_pend_d;
      err_q       <= err_d;
      len_q       <= len_d;
      out_data_q  <= out_data_d;
      out_vld_q   <= out_vld_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      out_err_q   <= out_err_d;
      out_len_q   <= out_len_d;
      frm_len_q   <= frm_len_d;
      frm_cnt_q   <= frm_cnt_d;
      err_cnt_q   <= err_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_data = out_data_q;
  assign out_vld  = out_vld_q;
  assign out_sof  = out_sof_q;
  assign out_eof  = out_eof_q;
  assign out_err  = out_err_q;
  assign frm_len  = frm_len_q;
  assign frm_cnt  = frm_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_tsmac_rx_frame_parser.sv
// Directed bench for tsmac_rx_frame_parser: FIFO word source, output beat recorder and
// hand-computed expectations per frame.
module tb_tsmac_rx_frame_parser;

  logic        clk;
  logic        rst_n;
  logic        fifo_rd_vld;
  logic [9:0]  fifo_rd_data;
  logic        fifo_rd_en;
  logic [7:0]  out_data;
  logic        out_vld;
  logic        out_rdy;
  logic        out_sof;
  logic        out_eof;
  logic        out_err;
  logic [15:0] frm_len;
  logic [15:0] frm_cnt;
  logic [15:0] err_cnt;
  logic [15:0] drop_cnt;

  tsmac_rx_frame_parser dut (
    .rd_clk      (clk),
    .rd_rst_n    (rst_n),
    .fifo_rd_vld (fifo_rd_vld),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .out_data    (out_data),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .out_err     (out_err),
    .frm_len     (frm_len),
    .frm_cnt     (frm_cnt),
    .err_cnt     (err_cnt),
    .drop_cnt    (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         n_total = 0;
  int         n_pass  = 0;
  logic [9:0] src[$];
  int         src_rd = 0;
  int         cyc = 0;
  int         rdy_mode = 0;
  int         stall_viol = 0;
  logic [7:0] rec_data[$];
  bit         rec_sof[$];
  bit         rec_eof[$];
  bit         rec_err[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Source and monitor: sample at negedge, advance the FIFO #1 after posedge.
  initial begin
    bit take;
    fifo_rd_vld  = 1'b0;
    fifo_rd_data = '0;
    out_rdy      = 1'b1;
    forever begin
      @(negedge clk);
      take = fifo_rd_vld && fifo_rd_en;
      if (out_vld && out_rdy) begin
        rec_data.push_back(out_data);
        rec_sof.push_back(out_sof);
        rec_eof.push_back(out_eof);
        rec_err.push_back(out_err);
      end
      if (out_vld && !out_rdy && !out_eof && fifo_rd_en) stall_viol++;
      @(posedge clk);
      #1;
      if (take) src_rd++;
      cyc++;
      out_rdy     = (rdy_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      fifo_rd_vld = (src_rd < src.size());
      fifo_rd_data = fifo_rd_vld ? src[src_rd] : 10'h000;
    end
  end

  task automatic push_frame(input int npre, input int nbytes, input int er_idx);
    logic [9:0] w;
    for (int i = 0; i < npre; i++) src.push_back(10'h155);
    src.push_back(10'h1D5);
    for (int i = 0; i < nbytes; i++) begin
      w = {(i == er_idx), 1'b1, 8'(i)};
      src.push_back(w);
    end
    src.push_back(10'h000);
  endtask

  task automatic clear_rec();
    rec_data.delete();
    rec_sof.delete();
    rec_eof.delete();
    rec_err.delete();
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    for (int k = 0; k < 4000 && quiet < 4; k++) begin
      @(negedge clk);
      if (src_rd == src.size() && !out_vld) quiet++;
      else quiet = 0;
    end
    check_eq({tag, "_done"}, 32'(quiet >= 4), 1);
  endtask

  task automatic check_frame(input string tag, input int n, input logic exp_err);
    int bad = 0;
    int sz;
    sz = rec_data.size();
    check_eq({tag, "_beats"}, sz, n);
    for (int i = 0; i < sz; i++) begin
      if (rec_data[i] != 8'(i) || rec_sof[i] != (i == 0) || rec_eof[i] != (i == n - 1) ||
          (rec_err[i] && i != n - 1)) bad++;
    end
    check_eq({tag, "_order"}, bad, 0);
    check_eq({tag, "_err"}, (sz > 0) ? 32'(rec_err[sz-1]) : 32'd2, 32'(exp_err));
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rd_en", fifo_rd_en, 0);
    check_eq("rst_outs", {out_vld, out_sof, out_eof, out_err, out_data}, 0);
    check_eq("rst_cnts", {frm_cnt, err_cnt}, 0);
    check_eq("rst_len_drop", {frm_len, drop_cnt}, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    clear_rec();
    push_frame(7, 64, -1);
    wait_idle("good");
    check_frame("good", 64, 1'b0);
    check_eq("good_frm_len", frm_len, 64);
    check_eq("good_frm_cnt", frm_cnt, 1);
    check_eq("good_err_cnt", err_cnt, 0);

    clear_rec();
    push_frame(7, 64, 10);
    wait_idle("rxer");
    check_frame("rxer", 64, 1'b1);
    check_eq("rxer_err_cnt", err_cnt, 1);
    check_eq("rxer_frm_cnt", frm_cnt, 1);

    clear_rec();
    push_frame(1, 20, -1);
    wait_idle("runt");
    check_frame("runt", 20, 1'b1);
    check_eq("runt_frm_len", frm_len, 20);
    check_eq("runt_err_cnt", err_cnt, 2);

    clear_rec();
    push_frame(7, 1530, -1);
    wait_idle("over");
    check_frame("over", 1522, 1'b1);
    check_eq("over_frm_len", frm_len, 1522);
    check_eq("over_err_cnt", err_cnt, 3);
    check_eq("over_drop_cnt", drop_cnt, 0);

    clear_rec();
    push_frame(7, 64, -1);
    wait_idle("after_over");
    check_frame("after_over", 64, 1'b0);
    check_eq("after_over_frm_cnt", frm_cnt, 2);

    clear_rec();
    src.push_back(10'h112);
    src.push_back(10'h155);
    src.push_back(10'h1D5);
    src.push_back(10'h000);
    src.push_back(10'h155);
    src.push_back(10'h155);
    src.push_back(10'h100);
    src.push_back(10'h1D5);
    src.push_back(10'h000);
    wait_idle("drop");
    check_eq("drop_beats", rec_data.size(), 0);
    check_eq("drop_cnt", drop_cnt, 2);

    clear_rec();
    stall_viol = 0;
    rdy_mode = 1;
    push_frame(7, 64, -1);
    wait_idle("stall");
    rdy_mode = 0;
    check_frame("stall", 64, 1'b0);
    check_eq("stall_rd_en", stall_viol, 0);
    check_eq("stall_frm_cnt", frm_cnt, 3);

    push_frame(7, 64, -1);
    for (int k = 0; k < 300 && src_rd < src.size() - 40; k++) @(posedge clk);
    check_eq("mid_reach", 32'(src_rd >= src.size() - 40), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rd_en", fifo_rd_en, 0);
    check_eq("mid_outs", {out_vld, out_sof, out_eof, out_err, out_data}, 0);
    check_eq("mid_cnts", {frm_cnt, err_cnt}, 0);
    check_eq("mid_len_drop", {frm_len, drop_cnt}, 0);
    clear_rec();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_idle("mid_tail");
    check_eq("mid_tail_beats", rec_data.size(), 0);
    check_eq("mid_tail_drop", drop_cnt, 1);

    clear_rec();
    push_frame(7, 64, -1);
    wait_idle("post_rst");
    check_frame("post_rst", 64, 1'b0);
    check_eq("post_rst_frm_cnt", frm_cnt, 1);
    check_eq("post_rst_frm_len", frm_len, 64);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
